dff_test_driver: RTL and testbench

- Synthesizable on-board self-test sequencer for the preset/clear D flip-flop experiment. It is the driving and checking end of the flip-flop's pre/clr/clk/d → q/qb interface.
- Steps through a fixed 6-entry vector table and drives the DUT pins.
- Samples q/qb at the end of each step and compares them against a golden model.
- Reports pass/fail to board LEDs.

---
 rtl/dff_test_pkg.sv | 39 +++
 rtl/dff_ref_model.sv | 32 +++
 rtl/dff_test_driver.sv | 223 ++++++++++++++++++++++
 tb/tb_dff_test_driver.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/dff_test_pkg.sv
// Shared types for the preset/clear flip-flop self-test: the step record,
// the fixed 6-entry stimulus table and the sequencer state encoding.
package dff_test_pkg;

    localparam int NUM_STEPS = 6;

    typedef struct packed {
        logic pre;
        logic clr;
        logic clk;
        logic d;
        logic exp_q;
        logic exp_qb;
    } step_t;

    // Advancing to the next step happens on the exit edge of SAMPLE, so no
    // separate NEXT cycle exists and a step is exactly HOLD_CYCLES long.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_APPLY,
        ST_HOLD,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    // Stimulus table, {pre,clr,clk,d,exp_q,exp_qb}; out-of-range gives idle pins.
    function automatic step_t step_vec(input logic [2:0] idx);
        case (idx)
            3'd0:    step_vec = step_t'(6'b1001_01);
            3'd1:    step_vec = step_t'(6'b0110_10);
            3'd2:    step_vec = step_t'(6'b1101_10);
            3'd3:    step_vec = step_t'(6'b1110_01);
            3'd4:    step_vec = step_t'(6'b0001_11);
            3'd5:    step_vec = step_t'(6'b0010_11);
            default: step_vec = step_t'(6'b1100_01);
        endcase
    endfunction

endpackage

// File: rtl/dff_ref_model.sv
// Golden preset/clear D flip-flop model, evaluated once per step from the
// step's pin levels, the previous dut_clk level and the previous model q.
module dff_ref_model (
    input  logic pre,
    input  logic clr,
    input  logic clk,
    input  logic d,
    input  logic prev_clk,
    input  logic prev_q,
    output logic exp_q,
    output logic exp_qb
);

    // Async preset/clear take priority; otherwise only a 0->1 clk edge loads d.
    always_comb begin
        exp_q  = prev_q;
        exp_qb = ~prev_q;
        if (!pre && !clr) begin
            exp_q  = 1'b1;
            exp_qb = 1'b1;
        end else begin
            if (!pre)
                exp_q = 1'b1;
            else if (!clr)
                exp_q = 1'b0;
            else if (clk && !prev_clk)
                exp_q = d;
            exp_qb = ~exp_q;
        end
    end

endmodule

// File: rtl/dff_test_driver.sv
// On-board self-test sequencer for the preset/clear D flip-flop experiment.
// Drives the table onto the DUT pins, samples synchronized q/qb at the last
// held cycle of each step and reports results on LED outputs.
// Build option: DFF_TEST_LOOP_EN makes the test run continuously.
module dff_test_driver
    import dff_test_pkg::*;
#(
    parameter int HOLD_CYCLES = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] fail_count,
    output logic [2:0] fail_step,
    output logic [2:0] step_idx,
    output logic       dut_pre,
    output logic       dut_clr,
    output logic       dut_clk,
    output logic       dut_d,
    input  logic       dut_q,
    input  logic       dut_qb
);

    localparam int            CW        = $clog2(HOLD_CYCLES) + 1;
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_CYCLES - 2);
    localparam logic [2:0]    LAST_STEP = 3'(NUM_STEPS - 1);

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [2:0]             step_idx_q, step_idx_d;
    logic [2:0]             fail_count_q, fail_count_d;
    logic [2:0]             fail_step_q, fail_step_d;
    logic                   busy_q, busy_d, done_q, done_d, pass_q, pass_d;
    logic                   dut_pre_q, dut_pre_d, dut_clr_q, dut_clr_d;
    logic                   dut_clk_q, dut_clk_d, dut_d_q, dut_d_d;
    logic                   exp_q_q, exp_q_d, exp_qb_q, exp_qb_d;
    logic                   armed_q;
    logic [SYNC_STAGES-1:0] q_sync_q, q_sync_d, qb_sync_q, qb_sync_d;
    logic                   model_q, model_qb, mismatch, start_ok;
    step_t                  cur_vec;

    assign cur_vec  = step_vec(step_idx_q);
    assign mismatch = {q_sync_q[SYNC_STAGES-1], qb_sync_q[SYNC_STAGES-1]} != {exp_q_q, exp_qb_q};
    // A start seen on the first edge after reset release is not trusted.
    assign start_ok = start && armed_q;

    dff_ref_model u_model (
        .pre      (cur_vec.pre),
        .clr      (cur_vec.clr),
        .clk      (cur_vec.clk),
        .d        (cur_vec.d),
        .prev_clk (dut_clk_q),
        .prev_q   (exp_q_q),
        .exp_q    (model_q),
        .exp_qb   (model_qb)
    );

    // Shift the asynchronous DUT outputs into the synchronizer chains.
    always_comb begin
        q_sync_d  = (q_sync_q << 1) | SYNC_STAGES'(dut_q);
        qb_sync_d = (qb_sync_q << 1) | SYNC_STAGES'(dut_qb);
    end

    // Synchronizer flops; nothing downstream sees dut_q/dut_qb directly.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            q_sync_q  <= '0;
            qb_sync_q <= '0;
        end else begin
            q_sync_q  <= q_sync_d;
            qb_sync_q <= qb_sync_d;
        end
    end

    // Next-state and registered-output logic for the sequencer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        step_idx_d   = step_idx_q;
        fail_count_d = fail_count_q;
        fail_step_d  = fail_step_q;
        busy_d       = busy_q;
        done_d       = done_q;
        pass_d       = pass_q;
        dut_pre_d    = dut_pre_q;
        dut_clr_d    = dut_clr_q;
        dut_clk_d    = dut_clk_q;
        dut_d_d      = dut_d_q;
        exp_q_d      = exp_q_q;
        exp_qb_d     = exp_qb_q;
`ifdef DFF_TEST_LOOP_EN
        done_d       = 1'b0;
        pass_d       = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    busy_d       = 1'b1;
                    done_d       = 1'b0;
                    pass_d       = 1'b0;
                    fail_count_d = '0;
                    fail_step_d  = '0;
                    step_idx_d   = '0;
                    state_d      = ST_APPLY;
                end
            end
            ST_APPLY: begin
                dut_pre_d = cur_vec.pre;
                dut_clr_d = cur_vec.clr;
                dut_clk_d = cur_vec.clk;
                dut_d_d   = cur_vec.d;
                exp_q_d   = model_q;
                exp_qb_d  = model_qb;
                cnt_d     = CW'(1);
                state_d   = ST_HOLD;
            end
            ST_HOLD: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == HOLD_LAST)
                    state_d = ST_SAMPLE;
            end
            ST_SAMPLE: begin
                if (mismatch) begin
                    if (fail_count_q == 3'd0)
                        fail_step_d = step_idx_q;
                    if (fail_count_q != 3'd7)
                        fail_count_d = fail_count_q + 3'd1;
                end
                if (step_idx_q == LAST_STEP) begin
`ifdef DFF_TEST_LOOP_EN
                    step_idx_d = '0;
                    done_d     = 1'b1;
                    pass_d     = (fail_count_d == 3'd0);
                    state_d    = ST_APPLY;
`else
                    state_d    = ST_DONE;
`endif
                end else begin
                    step_idx_d = step_idx_q + 3'd1;
                    state_d    = ST_APPLY;
                end
            end
            ST_DONE: begin
                busy_d     = 1'b0;
                done_d     = 1'b1;
                pass_d     = (fail_count_q == 3'd0);
                step_idx_d = '0;
                dut_pre_d  = 1'b1;
                dut_clr_d  = 1'b1;
                dut_clk_d  = 1'b0;
                dut_d_d    = 1'b0;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef DFF_TEST_LOOP_EN
        // In loop mode a start while running restarts and clears the tally.
        if (start_ok && state_q != ST_IDLE) begin
            fail_count_d = '0;
            fail_step_d  = '0;
            step_idx_d   = '0;
            state_d      = ST_APPLY;
        end
`endif
    end

    // Sequencer state and all registered outputs; clr aborts immediately.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            step_idx_q   <= '0;
            fail_count_q <= '0;
            fail_step_q  <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            dut_pre_q    <= 1'b1;
            dut_clr_q    <= 1'b1;
            dut_clk_q    <= 1'b0;
            dut_d_q      <= 1'b0;
            exp_q_q      <= 1'b0;
            exp_qb_q     <= 1'b1;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            step_idx_q   <= step_idx_d;
            fail_count_q <= fail_count_d;
            fail_step_q  <= fail_step_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            pass_q       <= pass_d;
            dut_pre_q    <= dut_pre_d;
            dut_clr_q    <= dut_clr_d;
            dut_clk_q    <= dut_clk_d;
            dut_d_q      <= dut_d_d;
            exp_q_q      <= exp_q_d;
            exp_qb_q     <= exp_qb_d;
            armed_q      <= 1'b1;
        end
    end

    // The model and the table's expected columns must agree at every sample.
    a_model_matches_table: assert property (@(posedge clk) disable iff (!clr)
        (state_q == ST_SAMPLE) |-> ({exp_q_q, exp_qb_q} == {cur_vec.exp_q, cur_vec.exp_qb}));

    assign busy       = busy_q;
    assign done       = done_q;
    assign pass       = pass_q;
    assign fail_count = fail_count_q;
    assign fail_step  = fail_step_q;
    assign step_idx   = step_idx_q;
    assign dut_pre    = dut_pre_q;
    assign dut_clr    = dut_clr_q;
    assign dut_clk    = dut_clk_q;
    assign dut_d      = dut_d_q;

endmodule

// File: tb/tb_dff_test_driver.sv
// Directed bench for dff_test_driver with a behavioural preset/clear DFF
// stand-in whose faults are selected by 'mode'.
module tb_dff_test_driver;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       busy, done, pass;
    logic [2:0] fail_count, fail_step, step_idx;
    logic       dut_pre, dut_clr, dut_clk, dut_d, dut_q, dut_qb;

    int n_cmp  = 0;
    int n_fail = 0;
    int mode   = 0;  // 0 good, 1 q stuck 0, 2 ignores clk edge, 3 q/qb inverted

    logic [3:0] vec_tbl [6] = '{4'b1001, 4'b0110, 4'b1101, 4'b1110, 4'b0001, 4'b0010};

    dff_test_driver #(.HOLD_CYCLES(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .clr(clr), .start(start), .busy(busy), .done(done), .pass(pass),
        .fail_count(fail_count), .fail_step(fail_step), .step_idx(step_idx),
        .dut_pre(dut_pre), .dut_clr(dut_clr), .dut_clk(dut_clk), .dut_d(dut_d),
        .dut_q(dut_q), .dut_qb(dut_qb)
    );

    always #5 clk = ~clk;

    // Behavioural flip-flop under test, settled mid-cycle after pins move.
    logic ff_q = 1'b0, ff_qb = 1'b1, last_clk = 1'b0;
    always @(negedge clk) begin
        if (!dut_pre) ff_q = 1'b1;
        else if (!dut_clr) ff_q = 1'b0;
        else if (dut_clk && !last_clk && mode != 2) ff_q = dut_d;
        ff_qb    = (!dut_pre && !dut_clr) ? 1'b1 : ~ff_q;
        last_clk = dut_clk;
    end
    assign dut_q  = (mode == 1) ? 1'b0 : (mode == 3) ? ~ff_q : ff_q;
    assign dut_qb = (mode == 3) ? ~ff_qb : ff_qb;

    // Pulse start and count clocks until done (bounded).
    task automatic do_run(output int cyc);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset;
        clr = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, pass, fail_count, fail_step, step_idx} !== 12'd0) begin
            n_fail++;
            $display("FAIL reset_status got %b want 0", {busy, done, pass, fail_count, fail_step, step_idx});
        end
        n_cmp++;
        if ({dut_pre, dut_clr, dut_clk, dut_d} !== 4'b1100) begin
            n_fail++;
            $display("FAIL reset_pins got %b want 1100", {dut_pre, dut_clr, dut_clk, dut_d});
        end
    endtask

    task automatic test_start_at_release;
        @(negedge clk);
        clr   = 1'b1;
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (busy !== 1'b0 || dut_clr !== 1'b1) begin
            n_fail++;
            $display("FAIL start_at_release busy=%b dut_clr=%b want 0,1", busy, dut_clr);
        end
    endtask

    task automatic test_correct;
        int cyc;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_after_start got %b want 1", busy);
        end
        while (done !== 1'b1 && cyc < 200) begin
            if (cyc >= 5 && (cyc - 5) % 8 == 0 && (cyc - 5) / 8 < 6) begin
                n_cmp++;
                if ({dut_pre, dut_clr, dut_clk, dut_d} !== vec_tbl[(cyc - 5) / 8] ||
                    step_idx !== 3'((cyc - 5) / 8)) begin
                    n_fail++;
                    $display("FAIL step_pins step %0d got %b idx %0d want %b", (cyc - 5) / 8,
                             {dut_pre, dut_clr, dut_clk, dut_d}, step_idx, vec_tbl[(cyc - 5) / 8]);
                end
            end
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (cyc !== 50) begin
            n_fail++;
            $display("FAIL correct_latency got %0d want 50", cyc);
        end
        n_cmp++;
        if ({busy, pass, fail_count, fail_step} !== {1'b0, 1'b1, 3'd0, 3'd0}) begin
            n_fail++;
            $display("FAIL correct_result busy=%b pass=%b cnt=%0d step=%0d want 0,1,0,0",
                     busy, pass, fail_count, fail_step);
        end
        repeat (5) @(negedge clk);
        n_cmp++;
        if ({done, pass, dut_pre, dut_clr, dut_clk, dut_d} !== 6'b11_1100) begin
            n_fail++;
            $display("FAIL done_held got %b want 111100", {done, pass, dut_pre, dut_clr, dut_clk, dut_d});
        end
    endtask

    task automatic test_stuck_q;
        int cyc;
        mode = 1;
        do_run(cyc);
        n_cmp++;
        if ({cyc == 50, pass, fail_count, fail_step} !== {1'b1, 1'b0, 3'd4, 3'd1}) begin
            n_fail++;
            $display("FAIL stuck_q cyc=%0d pass=%b cnt=%0d step=%0d want 50,0,4,1",
                     cyc, pass, fail_count, fail_step);
        end
    endtask

    task automatic test_no_clk;
        int cyc;
        mode = 2;
        do_run(cyc);
        n_cmp++;
        if ({cyc == 50, pass, fail_count, fail_step} !== {1'b1, 1'b0, 3'd1, 3'd3}) begin
            n_fail++;
            $display("FAIL no_clk cyc=%0d pass=%b cnt=%0d step=%0d want 50,0,1,3",
                     cyc, pass, fail_count, fail_step);
        end
    endtask

    task automatic test_all_inverted;
        int cyc;
        mode = 3;
        do_run(cyc);
        n_cmp++;
        if ({cyc == 50, pass, fail_count, fail_step} !== {1'b1, 1'b0, 3'd6, 3'd0}) begin
            n_fail++;
            $display("FAIL inverted cyc=%0d pass=%b cnt=%0d step=%0d want 50,0,6,0",
                     cyc, pass, fail_count, fail_step);
        end
        mode = 0;
    endtask

    task automatic test_abort;
        int cyc;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        n_cmp++;
        if (step_idx !== 3'd2 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_setup idx=%0d busy=%b want 2,1", step_idx, busy);
        end
        clr = 1'b0;
        #1;
        n_cmp++;
        if ({busy, done, pass, fail_count, fail_step, step_idx, dut_pre, dut_clr, dut_clk, dut_d}
            !== {12'd0, 4'b1100}) begin
            n_fail++;
            $display("FAIL abort_reset got %b want 0000000000001100",
                     {busy, done, pass, fail_count, fail_step, step_idx, dut_pre, dut_clr, dut_clk, dut_d});
        end
        @(negedge clk) clr = 1'b1;
        @(negedge clk);
        do_run(cyc);
        n_cmp++;
        if ({cyc == 50, pass, fail_count} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL abort_rerun cyc=%0d pass=%b cnt=%0d want 50,1,0", cyc, pass, fail_count);
        end
    endtask

    task automatic test_back_to_back;
        int cyc;
        mode = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        cyc = 1;
        while (done !== 1'b1 && cyc < 200) begin
            start = (cyc == 36);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if ({cyc == 50, pass, fail_count} !== {1'b1, 1'b1, 3'd0}) begin
            n_fail++;
            $display("FAIL start_while_busy cyc=%0d pass=%b cnt=%0d want 50,1,0", cyc, pass, fail_count);
        end
    endtask

    initial begin
        test_reset();
        test_start_at_release();
        test_correct();
        test_stuck_q();
        test_no_clk();
        test_all_inverted();
        test_abort();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
